// File: rtl/decade_counter_ctrl.sv
// Decade counter run controller.
// Sequences an external 0..9 counter through a run of wrap_limit 9->0 wraps,
// with a prescaled enable, pause/hold, abort and one-shot or periodic modes.
// Optional build macro: DECADE_COUNTER_CTRL_ERR_EN
//   defined   -> a count above 9 during RUN raises a sticky err and aborts to IDLE
//   undefined -> err is tied low and only cnt==9 is ever looked at
module decade_counter_ctrl #(
    parameter int PRESCALE = 1,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              mode,
    input  logic [WRAP_W-1:0] wrap_limit,
    input  logic [3:0]        cnt,
    output logic              en,
    output logic [WRAP_W-1:0] wraps,
    output logic              done,
    output logic              busy,
    output logic [1:0]        state,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    // Prescaler terminal value; PRESCALE is limited to 1..255 so 8 bits suffice.
    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    state_t              state_q, state_d;
    logic [7:0]          prescCnt_q, prescCnt_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic                done_q, done_d;

    logic                illegalCnt;
    logic                wrapEvent;
    logic                terminalEvent;
    logic [WRAP_W:0]     wrapsInc;
    logic [WRAP_W-1:0]   wrapsSat;
    logic [7:0]          prescNext;

`ifdef DECADE_COUNTER_CTRL_ERR_EN
    logic                err_q;

    assign illegalCnt = (cnt > 4'd9);

    // Sticky error flag: set by an out-of-range count while running, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == RUN) && illegalCnt) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign illegalCnt = 1'b0;
    assign err        = 1'b0;
`endif

    // Enable is suppressed in the cycle a pause request is seen so the counter holds its value.
    assign en = (state_q == RUN) && (prescCnt_q == PRESC_LAST) && !pause;

    assign wrapEvent     = en && (cnt == 4'd9);
    assign wrapsInc      = {1'b0, wraps_q} + {{WRAP_W{1'b0}}, 1'b1};
    assign wrapsSat      = (&wraps_q) ? wraps_q : wrapsInc[WRAP_W-1:0];
    assign terminalEvent = wrapEvent && (wrap_limit != '0) && (wrapsInc == {1'b0, wrap_limit});
    assign prescNext     = (prescCnt_q == PRESC_LAST) ? 8'd0 : (prescCnt_q + 8'd1);

    // Next-state, prescaler, wrap count and done pulse decisions.
    always_comb begin
        state_d    = state_q;
        prescCnt_d = prescCnt_q;
        wraps_d    = wraps_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    prescCnt_d = 8'd0;
                    wraps_d    = '0;
                end
            end

            RUN: begin
                if (stop || illegalCnt) begin
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = HOLD;
                end else begin
                    prescCnt_d = prescNext;
                    if (terminalEvent) begin
                        done_d = 1'b1;
                        if (!mode) begin
                            state_d = DONE;
                            wraps_d = wrap_limit;
                        end else begin
                            wraps_d = '0;
                        end
                    end else if (wrapEvent) begin
                        wraps_d = wrapsSat;
                    end
                end
            end

            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end

            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d    = RUN;
                    prescCnt_d = 8'd0;
                    wraps_d    = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, prescaler, wrap count and done registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prescCnt_q <= 8'd0;
            wraps_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescCnt_q <= prescCnt_d;
            wraps_q    <= wraps_d;
            done_q     <= done_d;
        end
    end

    assign wraps = wraps_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);

endmodule

// File: tb/tb_decade_counter_ctrl.sv
// Directed testbench for decade_counter_ctrl.
// Two instances share control inputs: dutA with PRESCALE=1, dutB with PRESCALE=3.
// Each drives its own behavioural decade counter; cnt of dutA can be overridden.
// Build with DECADE_COUNTER_CTRL_ERR_EN defined to exercise the error path.
module tb_decade_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] wrapLimit = 8'd0;
    logic       cntForce = 1'b0;
    logic [3:0] cntForceVal = 4'd0;

    logic [3:0] cntRegA, cntRegB, cntA, cntB;
    logic       enA, doneA, busyA, errA;
    logic       enB, doneB, busyB, errB;
    logic [7:0] wrapsA, wrapsB;
    logic [1:0] stateA, stateB;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    decade_counter_ctrl #(.PRESCALE(1), .WRAP_W(8)) dutA (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .wrap_limit(wrapLimit), .cnt(cntA), .en(enA), .wraps(wrapsA),
        .done(doneA), .busy(busyA), .state(stateA), .err(errA)
    );

    decade_counter_ctrl #(.PRESCALE(3), .WRAP_W(8)) dutB (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .wrap_limit(wrapLimit), .cnt(cntB), .en(enB), .wraps(wrapsB),
        .done(doneB), .busy(busyB), .state(stateB), .err(errB)
    );

    // Behavioural decade counters controlled by each instance's enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntRegA <= 4'd0;
            cntRegB <= 4'd0;
        end else begin
            if (enA) cntRegA <= (cntRegA == 4'd9) ? 4'd0 : cntRegA + 4'd1;
            if (enB) cntRegB <= (cntRegB == 4'd9) ? 4'd0 : cntRegB + 4'd1;
        end
    end

    assign cntA = cntForce ? cntForceVal : cntRegA;
    assign cntB = cntRegB;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        start = 0; stop = 0; pause = 0; mode = 0; wrapLimit = 0;
        cntForce = 0; cntForceVal = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        #2;
        testsRun++; if (stateA !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_state: got %0d expected 0", stateA); end
        testsRun++; if (enA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_en: got %0b expected 0", enA); end
        testsRun++; if (busyA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b expected 0", busyA); end
        testsRun++; if (wrapsA !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_wraps: got %0d expected 0", wrapsA); end
        testsRun++; if (doneA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %0b expected 0", doneA); end
        testsRun++; if (errA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %0b expected 0", errA); end
        testsRun++; if (stateB !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_stateB: got %0d expected 0", stateB); end
    endtask

    task automatic test_oneshot();
        int  enCnt = 0;
        bit  midChecked = 0;
        bit  gotDone = 0;
        doReset();
        mode = 0; wrapLimit = 8'd2;
        start = 1; tick(); start = 0;
        testsRun++; if (stateA !== 2'b01) begin testsFailed++; $display("[TB] FAIL oneshot_run_state: got %0d expected 1", stateA); end
        testsRun++; if (busyA !== 1'b1) begin testsFailed++; $display("[TB] FAIL oneshot_busy: got %0b expected 1", busyA); end
        for (int i = 0; i < 60; i++) begin
            if (doneA) begin gotDone = 1; break; end
            if (enA) enCnt++;
            tick();
            if (enCnt == 10 && !midChecked) begin
                midChecked = 1;
                testsRun++; if (wrapsA !== 8'd1) begin testsFailed++; $display("[TB] FAIL oneshot_wraps_mid: got %0d expected 1", wrapsA); end
            end
        end
        testsRun++; if (gotDone !== 1'b1) begin testsFailed++; $display("[TB] FAIL oneshot_done_seen: got %0b expected 1", gotDone); end
        testsRun++; if (enCnt != 20) begin testsFailed++; $display("[TB] FAIL oneshot_en_count: got %0d expected 20", enCnt); end
        testsRun++; if (stateA !== 2'b11) begin testsFailed++; $display("[TB] FAIL oneshot_done_state: got %0d expected 3", stateA); end
        testsRun++; if (enA !== 1'b0) begin testsFailed++; $display("[TB] FAIL oneshot_en_in_done: got %0b expected 0", enA); end
        testsRun++; if (wrapsA !== 8'd2) begin testsFailed++; $display("[TB] FAIL oneshot_wraps_final: got %0d expected 2", wrapsA); end
        tick();
        testsRun++; if (doneA !== 1'b0) begin testsFailed++; $display("[TB] FAIL oneshot_done_single: got %0b expected 0", doneA); end
    endtask

    task automatic test_prescale();
        int runCyc = 0;
        int enCnt = 0;
        int badPhase = 0;
        bit gotDone = 0;
        doReset();
        mode = 0; wrapLimit = 8'd1;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 120; i++) begin
            if (doneB) begin gotDone = 1; break; end
            if (stateB == 2'b01) begin
                if (enB) begin
                    enCnt++;
                    if (runCyc % 3 != 2) badPhase++;
                end
                runCyc++;
            end
            tick();
        end
        testsRun++; if (gotDone !== 1'b1) begin testsFailed++; $display("[TB] FAIL prescale_done_seen: got %0b expected 1", gotDone); end
        testsRun++; if (runCyc != 30) begin testsFailed++; $display("[TB] FAIL prescale_run_cycles: got %0d expected 30", runCyc); end
        testsRun++; if (enCnt != 10) begin testsFailed++; $display("[TB] FAIL prescale_en_count: got %0d expected 10", enCnt); end
        testsRun++; if (badPhase != 0) begin testsFailed++; $display("[TB] FAIL prescale_en_phase: got %0d off-phase pulses expected 0", badPhase); end
        testsRun++; if (stateB !== 2'b11) begin testsFailed++; $display("[TB] FAIL prescale_state: got %0d expected 3", stateB); end
    endtask

    task automatic test_periodic();
        int enCnt = 0;
        int doneCnt = 0;
        int bad = 0;
        doReset();
        mode = 1; wrapLimit = 8'd1;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 35; i++) begin
            if (doneA) begin
                doneCnt++;
                if ((enCnt % 10) != 0 || wrapsA !== 8'd0 || stateA !== 2'b01) bad++;
            end
            if (enA) enCnt++;
            tick();
        end
        testsRun++; if (doneCnt != 3) begin testsFailed++; $display("[TB] FAIL periodic_done_count: got %0d expected 3", doneCnt); end
        testsRun++; if (bad != 0) begin testsFailed++; $display("[TB] FAIL periodic_done_position: got %0d bad pulses expected 0", bad); end
        testsRun++; if (enCnt != 35) begin testsFailed++; $display("[TB] FAIL periodic_en_count: got %0d expected 35", enCnt); end
        testsRun++; if (stateA !== 2'b01) begin testsFailed++; $display("[TB] FAIL periodic_state: got %0d expected 1", stateA); end
        stop = 1; tick(); stop = 0;
        testsRun++; if (stateA !== 2'b00) begin testsFailed++; $display("[TB] FAIL periodic_stop_state: got %0d expected 0", stateA); end
    endtask

    task automatic test_pause();
        int enCnt = 0;
        int heldBad = 0;
        bit gotDone = 0;
        doReset();
        mode = 0; wrapLimit = 8'd1;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 20; i++) begin
            if (cntA == 4'd4) break;
            if (enA) enCnt++;
            tick();
        end
        pause = 1;
        #1;
        testsRun++; if (enA !== 1'b0) begin testsFailed++; $display("[TB] FAIL pause_en_same_cycle: got %0b expected 0", enA); end
        tick();
        testsRun++; if (stateA !== 2'b10) begin testsFailed++; $display("[TB] FAIL pause_hold_state: got %0d expected 2", stateA); end
        testsRun++; if (busyA !== 1'b1) begin testsFailed++; $display("[TB] FAIL pause_hold_busy: got %0b expected 1", busyA); end
        start = 1;
        for (int i = 0; i < 4; i++) begin
            if (enA !== 1'b0 || cntA !== 4'd4) heldBad++;
            tick();
        end
        start = 0;
        testsRun++; if (heldBad != 0) begin testsFailed++; $display("[TB] FAIL pause_held: got %0d bad cycles expected 0", heldBad); end
        testsRun++; if (stateA !== 2'b10) begin testsFailed++; $display("[TB] FAIL pause_start_ignored: got %0d expected 2", stateA); end
        testsRun++; if (cntA !== 4'd4) begin testsFailed++; $display("[TB] FAIL pause_cnt_held: got %0d expected 4", cntA); end
        pause = 0; tick();
        testsRun++; if (stateA !== 2'b01) begin testsFailed++; $display("[TB] FAIL pause_resume_state: got %0d expected 1", stateA); end
        for (int i = 0; i < 40; i++) begin
            if (doneA) begin gotDone = 1; break; end
            if (enA) enCnt++;
            tick();
        end
        testsRun++; if (gotDone !== 1'b1) begin testsFailed++; $display("[TB] FAIL pause_done_seen: got %0b expected 1", gotDone); end
        testsRun++; if (enCnt != 10) begin testsFailed++; $display("[TB] FAIL pause_total_en: got %0d expected 10", enCnt); end
    endtask

    task automatic test_stop_terminal();
        doReset();
        mode = 0; wrapLimit = 8'd1;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 20; i++) begin
            if (enA && cntA == 4'd9) break;
            tick();
        end
        testsRun++; if (cntA !== 4'd9) begin testsFailed++; $display("[TB] FAIL stopterm_reach9: got %0d expected 9", cntA); end
        stop = 1; tick(); stop = 0;
        testsRun++; if (stateA !== 2'b00) begin testsFailed++; $display("[TB] FAIL stopterm_state: got %0d expected 0", stateA); end
        testsRun++; if (doneA !== 1'b0) begin testsFailed++; $display("[TB] FAIL stopterm_no_done: got %0b expected 0", doneA); end
        tick();
        testsRun++; if (doneA !== 1'b0) begin testsFailed++; $display("[TB] FAIL stopterm_no_done_late: got %0b expected 0", doneA); end
        // Reset in the middle of a run with one wrap already counted.
        wrapLimit = 8'd2;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 12; i++) tick();
        testsRun++; if (wrapsA !== 8'd1) begin testsFailed++; $display("[TB] FAIL midreset_pre_wraps: got %0d expected 1", wrapsA); end
        rst_n = 0;
        #2;
        testsRun++; if (stateA !== 2'b00) begin testsFailed++; $display("[TB] FAIL midreset_state: got %0d expected 0", stateA); end
        testsRun++; if (enA !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_en: got %0b expected 0", enA); end
        testsRun++; if (busyA !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_busy: got %0b expected 0", busyA); end
        testsRun++; if (wrapsA !== 8'd0) begin testsFailed++; $display("[TB] FAIL midreset_wraps: got %0d expected 0", wrapsA); end
        testsRun++; if (doneA !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_done: got %0b expected 0", doneA); end
    endtask

    task automatic test_done_exit();
        bit reached = 0;
        doReset();
        mode = 0; wrapLimit = 8'd1;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 30; i++) begin
            if (stateA == 2'b11) begin reached = 1; break; end
            tick();
        end
        testsRun++; if (reached !== 1'b1) begin testsFailed++; $display("[TB] FAIL doneexit_reach1: got %0b expected 1", reached); end
        start = 1; tick(); start = 0;
        testsRun++; if (stateA !== 2'b01) begin testsFailed++; $display("[TB] FAIL doneexit_restart_state: got %0d expected 1", stateA); end
        testsRun++; if (wrapsA !== 8'd0) begin testsFailed++; $display("[TB] FAIL doneexit_restart_wraps: got %0d expected 0", wrapsA); end
        reached = 0;
        for (int i = 0; i < 30; i++) begin
            if (stateA == 2'b11) begin reached = 1; break; end
            tick();
        end
        testsRun++; if (reached !== 1'b1) begin testsFailed++; $display("[TB] FAIL doneexit_reach2: got %0b expected 1", reached); end
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        testsRun++; if (stateA !== 2'b00) begin testsFailed++; $display("[TB] FAIL doneexit_startstop_state: got %0d expected 0", stateA); end
        testsRun++; if (wrapsA !== 8'd1) begin testsFailed++; $display("[TB] FAIL doneexit_wraps_kept: got %0d expected 1", wrapsA); end
    endtask

    task automatic test_err();
        doReset();
        mode = 0; wrapLimit = 8'd0;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 3; i++) tick();
        cntForce = 1; cntForceVal = 4'd12;
        tick();
`ifdef DECADE_COUNTER_CTRL_ERR_EN
        testsRun++; if (errA !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_set: got %0b expected 1", errA); end
        testsRun++; if (stateA !== 2'b00) begin testsFailed++; $display("[TB] FAIL err_state: got %0d expected 0", stateA); end
        cntForce = 0;
        tick(); tick();
        testsRun++; if (errA !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_sticky: got %0b expected 1", errA); end
        rst_n = 0;
        #2;
        testsRun++; if (errA !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_reset_clear: got %0b expected 0", errA); end
        rst_n = 1;
        tick();
`else
        testsRun++; if (errA !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_tied: got %0b expected 0", errA); end
        testsRun++; if (stateA !== 2'b01) begin testsFailed++; $display("[TB] FAIL err_ignored_state: got %0d expected 1", stateA); end
        cntForce = 0;
        stop = 1; tick(); stop = 0;
        testsRun++; if (stateA !== 2'b00) begin testsFailed++; $display("[TB] FAIL err_stop_state: got %0d expected 0", stateA); end
`endif
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_prescale();
        test_periodic();
        test_pause();
        test_stop_terminal();
        test_done_exit();
        test_err();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/decade_counter_ctrl.md
DECADE_COUNTER_CTRL -- requirements
Module: decade_counter_ctrl

Interface
REQ-001 Parameter PRESCALE, default 1, number of clk cycles per counter enable pulse (legal 1..255).
REQ-002 Parameter WRAP_W, default 8, width of wrap_limit and wraps.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  level; begin or restart a counting run.
REQ-006 stop  input  1  level; abort run and return to IDLE.
REQ-007 pause  input  1  level; hold counting while high.
REQ-008 mode  input  1  0 = one-shot, 1 = periodic.
REQ-009 wrap_limit  input  WRAP_W  number of 9->0 wraps per run; 0 = free-run.
REQ-010 cnt  input  4  present value of the controlled decade counter.
REQ-011 en  output  1  enable to the decade counter.
REQ-012 wraps  output  WRAP_W  wraps completed in the current run.
REQ-013 done  output  1  one-cycle pulse at run or period completion.
REQ-014 busy  output  1  high in RUN or HOLD.
REQ-015 state  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11.
REQ-016 err  output  1  sticky illegal-count flag.

Function
REQ-017 en SHALL be combinational: state==RUN and prescaler==PRESCALE-1; en SHALL be 0 in IDLE, HOLD and DONE.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 in RUN, wrap to 0, freeze in HOLD, and clear on entry to RUN from IDLE or DONE.
REQ-019 A wrap event SHALL be en==1 and cnt==9 in the same cycle; wraps SHALL increment on that edge, saturating at all-ones.
REQ-020 Terminal event: wrap event with wrap_limit!=0 and wraps+1==wrap_limit.
REQ-021 IDLE: start -> RUN, clearing wraps and prescaler; otherwise stay.
REQ-022 RUN priority: stop -> IDLE; else pause -> HOLD (en=0 that cycle); else terminal event with mode=0 -> DONE, wraps=wrap_limit; else terminal event with mode=1 -> stay RUN, wraps cleared to 0.
REQ-023 done SHALL pulse high for exactly one cycle following each terminal event; no done when stop or pause wins the same cycle.
REQ-024 HOLD: stop -> IDLE; pause low -> RUN, prescaler resuming from its held value.
REQ-025 DONE: start -> RUN with wraps cleared; stop -> IDLE, wraps retained; start and stop together -> IDLE.
REQ-026 start while in RUN or HOLD SHALL be ignored.
REQ-027 busy SHALL equal (state==RUN or state==HOLD).

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, prescaler=0, wraps=0, done=0, err=0; en=0 and busy=0 follow.
REQ-029 Reset mid-run SHALL abandon the run with no done pulse; the controlled counter itself is not reset by this block.

Configuration
REQ-030 Macro DECADE_COUNTER_CTRL_ERR_EN defined: cnt>9 while state==RUN SHALL set err and force IDLE on that edge; err clears only on reset.
REQ-031 Macro undefined: err SHALL be tied 0 and cnt>9 SHALL be ignored (only cnt==9 compared).

Verification
REQ-032 PRESCALE=1, mode=0, wrap_limit=2, start pulse, counter from 0 -> en high 20 cycles, wraps 1 then 2, single done pulse, state=DONE, en=0.
REQ-033 PRESCALE=3, wrap_limit=1 -> en high every 3rd cycle, done after 30 cycles in RUN.
REQ-034 mode=1, wrap_limit=1 -> done pulses every 10 en pulses, wraps returns to 0 each time, state stays RUN.
REQ-035 pause high for 5 cycles at cnt=4 -> state=HOLD, en=0, cnt held at 4; release -> counting resumes, total en pulses unchanged.
REQ-036 stop asserted in the same cycle as the terminal wrap -> state=IDLE, no done pulse; rst_n low mid-run -> all outputs 0 asynchronously.
REQ-037 With DECADE_COUNTER_CTRL_ERR_EN, drive cnt=12 in RUN -> err=1, state=IDLE, err held until rst_n.
